// File: rtl/arty_io_pkg.sv
// Shared types and defaults for the Arty board input debouncer.
package arty_io_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_e;

  // 2.5 ms at a 100 MHz system clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debouncer: two-flop synchronizer, accept/reject FSM with
// stability counter, and registered edge pulses.
module debounce_ch
  import arty_io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic evt_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic SINGLE = (DEBOUNCE_CYCLES == 1);

  logic            sync_p0;
  logic            sync_p1;
  db_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic            accept_hi;
  logic            accept_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RESET_LEVEL;
      sync_p1 <= RESET_LEVEL;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // A single-cycle build accepts straight from the stable state.
  always_comb begin
    accept_hi = 1'b0;
    accept_lo = 1'b0;
    case (state)
      STABLE_LO: accept_hi = sync_p1 && SINGLE;
      PEND_HI:   accept_hi = sync_p1 && (cnt == LAST);
      STABLE_HI: accept_lo = !sync_p1 && SINGLE;
      PEND_LO:   accept_lo = !sync_p1 && (cnt == LAST);
      default: ;
    endcase
  end

  assign evt_next = accept_hi | accept_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
      cnt   <= '0;
      db    <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept_hi;
      fall <= accept_lo;
      case (state)
        STABLE_LO: begin
          if (accept_hi) begin
            state <= STABLE_HI;
            db    <= 1'b1;
            cnt   <= '0;
          end else if (sync_p1) begin
            state <= PEND_HI;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        PEND_HI: begin
          if (!sync_p1) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (accept_hi) begin
            state <= STABLE_HI;
            db    <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (accept_lo) begin
            state <= STABLE_LO;
            db    <= 1'b0;
            cnt   <= '0;
          end else if (!sync_p1) begin
            state <= PEND_LO;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        PEND_LO: begin
          if (sync_p1) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (accept_lo) begin
            state <= STABLE_LO;
            db    <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          db    <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arty_input_debounce.sv
// Board input debouncer: one independent debounce_ch per button/switch plus
// a shared registered "any edge" flag for the SoC GPIO block.
module arty_input_debounce
  import arty_io_pkg::*;
#(
  parameter int                NUM_CH          = 8,
  parameter int                DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [NUM_CH-1:0] RESET_LEVEL     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] db_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              change_o
);

  logic [NUM_CH-1:0] evt_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw_i[i]),
      .db       (db_o[i]),
      .rise     (rise_o[i]),
      .fall     (fall_o[i]),
      .evt_next (evt_next[i])
    );
  end

  // Registered from the channels' next-cycle events so it lines up with rise_o/fall_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_o <= 1'b0;
    end else begin
      change_o <= |evt_next;
    end
  end

endmodule
